// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the MEM-stage LSU (master) and the data memory (slave).
interface mem_stage_lsu_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: lane steering, load formatting and an IDLE/WAIT/DONE bus FSM.
// Build macro MISALIGN_TRAP_EN: flag and suppress misaligned halfword/word accesses.
module mem_stage_lsu (
    input  logic            clk,
    input  logic            rst,
    input  logic            MemReadM,
    input  logic            MemWriteM,
    input  logic [2:0]      Funct3M,
    input  logic [31:0]     ALUResultM,
    input  logic [31:0]     WriteDataM,
    output logic [31:0]     ReadDataM,
    output logic            StallM,
    output logic            MisalignM,
    mem_stage_lsu_if.master dmem
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] rdata_q;
    logic        capture;
    logic        req_raw;
    logic        is_byte, is_half, is_unsigned;
    logic        misaligned, pending;
    logic [1:0]  off;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_fmt;

    assign off         = ALUResultM[1:0];
    assign is_byte     = (Funct3M[1:0] == 2'b00);
    assign is_half     = (Funct3M[1:0] == 2'b01);
    assign is_unsigned = Funct3M[2];

`ifdef MISALIGN_TRAP_EN
    assign misaligned = (is_half && off[0]) || (!is_byte && !is_half && (off != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign pending = (MemReadM || MemWriteM) && !misaligned;

    // Store lane steering; loads always fetch the whole word.
    always_comb begin
        dmem.dmem_be    = 4'b1111;
        dmem.dmem_wdata = WriteDataM;
        if (MemWriteM) begin
            if (is_byte) begin
                dmem.dmem_be    = 4'b0001 << off;
                dmem.dmem_wdata = {4{WriteDataM[7:0]}};
            end else if (is_half) begin
                dmem.dmem_be    = off[1] ? 4'b1100 : 4'b0011;
                dmem.dmem_wdata = {2{WriteDataM[15:0]}};
            end
        end
    end

    assign lane_b = dmem.dmem_rdata[{off, 3'b000} +: 8];
    assign lane_h = off[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];

    always_comb begin
        if (is_byte) begin
            load_fmt = {{24{!is_unsigned && lane_b[7]}}, lane_b};
        end else if (is_half) begin
            load_fmt = {{16{!is_unsigned && lane_h[15]}}, lane_h};
        end else begin
            load_fmt = dmem.dmem_rdata;
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_next = state;
        req_raw    = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    req_raw = 1'b1;
                    if (dmem.dmem_ready) begin
                        capture    = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                req_raw = 1'b1;
                if (dmem.dmem_ready) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rdata_q <= 32'd0;
        end else begin
            state <= state_next;
            if (capture) begin
                rdata_q <= MemWriteM ? 32'd0 : load_fmt;
            end
        end
    end

    // Reset overrides every control output combinationally.
    assign dmem.dmem_req  = req_raw && !rst;
    assign dmem.dmem_we   = req_raw && MemWriteM && !rst;
    assign dmem.dmem_addr = {ALUResultM[31:2], 2'b00};
    assign StallM         = req_raw && !rst;
    assign MisalignM      = misaligned && (MemReadM || MemWriteM) && (state == IDLE) && !rst;
    assign ReadDataM      = ((state == DONE) && !rst) ? rdata_q : 32'd0;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed scenarios plus randomized accesses vs a behavioural model.
module tb_mem_stage_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        MemReadM, MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM, MisalignM;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage_lsu_if bus();

    mem_stage_lsu dut (
        .clk        (clk),
        .rst        (rst),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .Funct3M    (Funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .MisalignM  (MisalignM),
        .dmem       (bus)
    );

    always #5 clk = ~clk;

    // Access size in bytes from funct3: 000/100 byte, 001/101 half, everything else word.
    function automatic int acc_size(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] w);
        int unsigned v;
        if (acc_size(f3) == 1) begin
            v = (w >> (8 * addr[1:0])) & 32'hFF;
            if (f3 == 3'b000 && v >= 128) v = v + 32'hFFFFFF00;
        end else if (acc_size(f3) == 2) begin
            v = (w >> (16 * addr[1])) & 32'hFFFF;
            if (f3 == 3'b001 && v >= 32768) v = v + 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [3:0] model_be(input logic wr, input logic [2:0] f3,
                                            input logic [31:0] addr);
        if (!wr) return 4'hF;
        if (acc_size(f3) == 1) return 4'(1 << addr[1:0]);
        if (acc_size(f3) == 2) return 4'(3 << (2 * addr[1]));
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (acc_size(f3) == 1) return (wd & 32'hFF) * 32'h01010101;
        if (acc_size(f3) == 2) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic bit model_mis(input logic [2:0] f3, input logic [31:0] addr);
`ifdef MISALIGN_TRAP_EN
        return (acc_size(f3) == 2 && addr[0]) || (acc_size(f3) == 4 && addr[1:0] != 2'b00);
`else
        return (f3 == 3'bxxx) && (addr == 32'hx);
`endif
    endfunction

    // Drives one access from IDLE; the bus answers after `waits` wait cycles.
    task automatic run_access(input string name, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rw, input int waits);
        int stalls;
        bit done;
        stalls = 0;
        done   = 0;
        MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = addr; WriteDataM = wd;
        bus.dmem_ready = (waits == 0);
        bus.dmem_rdata = (waits == 0) ? rw : $urandom;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (StallM) begin
                stalls++;
                n_checks++;
                if (bus.dmem_req !== 1'b1) begin
                    n_fail++; $display("FAIL %s req: got %b expected 1", name, bus.dmem_req);
                end
                if (c == 0) begin
                    n_checks++;
                    if (bus.dmem_be !== model_be(wr, f3, addr)) begin
                        n_fail++;
                        $display("FAIL %s be: got %b expected %b", name, bus.dmem_be, model_be(wr, f3, addr));
                    end
                    n_checks++;
                    if (bus.dmem_we !== wr) begin
                        n_fail++; $display("FAIL %s we: got %b expected %b", name, bus.dmem_we, wr);
                    end
                    n_checks++;
                    if (bus.dmem_addr !== (addr & 32'hFFFFFFFC)) begin
                        n_fail++;
                        $display("FAIL %s addr: got %h expected %h", name, bus.dmem_addr, addr & 32'hFFFFFFFC);
                    end
                    n_checks++;
                    if (MisalignM !== 1'b0) begin
                        n_fail++; $display("FAIL %s misalign: got %b expected 0", name, MisalignM);
                    end
                    if (wr) begin
                        n_checks++;
                        if (bus.dmem_wdata !== model_wdata(f3, wd)) begin
                            n_fail++;
                            $display("FAIL %s wdata: got %h expected %h", name, bus.dmem_wdata, model_wdata(f3, wd));
                        end
                    end
                end
                @(posedge clk); #1;
                if (c + 1 > waits) begin
                    bus.dmem_ready = 1'($urandom_range(0, 1));
                    bus.dmem_rdata = $urandom;
                end else begin
                    bus.dmem_ready = (c + 1 == waits);
                    bus.dmem_rdata = (c + 1 == waits) ? rw : $urandom;
                end
            end else begin
                done = 1;
                n_checks++;
                if (bus.dmem_req !== 1'b0) begin
                    n_fail++; $display("FAIL %s done_req: got %b expected 0", name, bus.dmem_req);
                end
                if (!wr) begin
                    n_checks++;
                    if (ReadDataM !== model_load(f3, addr, rw)) begin
                        n_fail++;
                        $display("FAIL %s rdata: got %h expected %h", name, ReadDataM, model_load(f3, addr, rw));
                    end
                end
            end
        end
        if (!done) begin
            n_fail++; $display("FAIL %s timeout: stall never released", name);
        end
        n_checks++;
        if (stalls != waits + 1) begin
            n_fail++; $display("FAIL %s stall_cycles: got %0d expected %0d", name, stalls, waits + 1);
        end
        @(posedge clk); #1;
        MemReadM = 1'b0; MemWriteM = 1'b0;
        bus.dmem_ready = 1'($urandom_range(0, 1));
        bus.dmem_rdata = $urandom;
        @(negedge clk);
        n_checks++;
        if (StallM !== 1'b0 || bus.dmem_req !== 1'b0 || ReadDataM !== 32'd0) begin
            n_fail++;
            $display("FAIL %s idle_after: got stall=%b req=%b rdata=%h expected 0/0/0",
                     name, StallM, bus.dmem_req, ReadDataM);
        end
        @(posedge clk); #1;
        bus.dmem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        MemReadM = 1'b1; MemWriteM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h101; WriteDataM = 32'h5;
        bus.dmem_ready = 1'b1; bus.dmem_rdata = 32'hA5A5A5A5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.dmem_req, bus.dmem_we, StallM, MisalignM} !== 4'b0000 || ReadDataM !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: got req=%b we=%b stall=%b mis=%b rdata=%h expected all 0",
                         bus.dmem_req, bus.dmem_we, StallM, MisalignM, ReadDataM);
            end
        end
        @(posedge clk); #1;
        MemReadM = 1'b0; MemWriteM = 1'b0; bus.dmem_ready = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (StallM !== 1'b0 || ReadDataM !== 32'd0) begin
            n_fail++; $display("FAIL reset_release: got stall=%b rdata=%h expected 0", StallM, ReadDataM);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run_access("lw_0x100",  1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        run_access("lb_0x103",  1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456, 3);
        run_access("lbu_0x103", 1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80123456, 3);
        run_access("sh_0x202",  1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 1);
        run_access("lhu_0x102", 1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h9ABC0000, 2);
        run_access("lw_f3_111", 1'b1, 1'b0, 3'b111, 32'h104, 32'h0, 32'h01234567, 0);
        run_access("rd_wr_both", 1'b1, 1'b1, 3'b000, 32'h301, 32'h000000EE, 32'h0, 0);
    endtask

    task automatic test_reset_mid_wait();
        MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010; ALUResultM = 32'h300;
        bus.dmem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (StallM !== 1'b1) begin
                n_fail++; $display("FAIL mid_wait_stall: got %b expected 1", StallM);
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (StallM !== 1'b0 || bus.dmem_req !== 1'b0 || ReadDataM !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_wait_rst: got stall=%b req=%b rdata=%h expected 0", StallM, bus.dmem_req, ReadDataM);
        end
        @(posedge clk); #1;
        rst = 1'b0; MemReadM = 1'b0;
        @(negedge clk);
        n_checks++;
        if (StallM !== 1'b0 || bus.dmem_req !== 1'b0 || ReadDataM !== 32'd0) begin
            n_fail++;
            $display("FAIL after_rst_idle: got stall=%b req=%b rdata=%h expected 0", StallM, bus.dmem_req, ReadDataM);
        end
        @(posedge clk); #1;
        run_access("lw_after_rst", 1'b1, 1'b0, 3'b010, 32'h304, 32'h0, 32'hCAFEF00D, 0);
    endtask

    task automatic test_misalign();
`ifdef MISALIGN_TRAP_EN
        MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010; ALUResultM = 32'h101;
        bus.dmem_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (MisalignM !== 1'b1 || bus.dmem_req !== 1'b0 || StallM !== 1'b0 || ReadDataM !== 32'd0) begin
            n_fail++;
            $display("FAIL lw_mis_trap: got mis=%b req=%b stall=%b rdata=%h expected 1/0/0/0",
                     MisalignM, bus.dmem_req, StallM, ReadDataM);
        end
        @(posedge clk); #1;
        MemReadM = 1'b0; MemWriteM = 1'b1; Funct3M = 3'b001; ALUResultM = 32'h203;
        @(negedge clk);
        n_checks++;
        if (MisalignM !== 1'b1 || bus.dmem_req !== 1'b0 || StallM !== 1'b0) begin
            n_fail++;
            $display("FAIL sh_mis_trap: got mis=%b req=%b stall=%b expected 1/0/0", MisalignM, bus.dmem_req, StallM);
        end
        @(posedge clk); #1;
        MemWriteM = 1'b0; bus.dmem_ready = 1'b0;
        run_access("lh_aligned", 1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h7FFF1234, 1);
`else
        run_access("lw_0x101", 1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h13579BDF, 1);
        run_access("lh_0x103", 1'b1, 1'b0, 3'b001, 32'h103, 32'h0, 32'h8001ABCD, 0);
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] wa, wb;
        wa = $urandom; wb = $urandom;
        MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010; ALUResultM = 32'h400;
        bus.dmem_ready = 1'b1; bus.dmem_rdata = wa;
        @(negedge clk);
        n_checks++;
        if (StallM !== 1'b1) begin
            n_fail++; $display("FAIL b2b_stall1: got %b expected 1", StallM);
        end
        @(posedge clk); #1;
        bus.dmem_rdata = wb;
        @(negedge clk);
        n_checks++;
        if (StallM !== 1'b0 || ReadDataM !== wa) begin
            n_fail++; $display("FAIL b2b_done1: got stall=%b rdata=%h expected 0/%h", StallM, ReadDataM, wa);
        end
        @(posedge clk); #1;
        ALUResultM = 32'h404;
        @(negedge clk);
        n_checks++;
        if (StallM !== 1'b1 || bus.dmem_req !== 1'b1 || bus.dmem_addr !== 32'h404) begin
            n_fail++;
            $display("FAIL b2b_req2: got stall=%b req=%b addr=%h expected 1/1/404", StallM, bus.dmem_req, bus.dmem_addr);
        end
        @(posedge clk); #1;
        bus.dmem_rdata = $urandom;
        @(negedge clk);
        n_checks++;
        if (StallM !== 1'b0 || ReadDataM !== wb) begin
            n_fail++; $display("FAIL b2b_done2: got stall=%b rdata=%h expected 0/%h", StallM, ReadDataM, wb);
        end
        @(posedge clk); #1;
        MemReadM = 1'b0; bus.dmem_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int kind;
        logic rd, wr;
        logic [2:0] f3;
        logic [31:0] addr;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 2);
            rd   = (kind != 1);
            wr   = (kind != 0);
            f3   = wr ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            addr = $urandom;
            if (model_mis(f3, addr)) addr[1:0] = 2'b00;
            run_access("random", rd, wr, f3, addr, $urandom, $urandom, $urandom_range(0, 3));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'b000; ALUResultM = 32'd0; WriteDataM = 32'd0;
        bus.dmem_ready = 1'b0; bus.dmem_rdata = 32'd0;
        @(posedge clk); #1;
        test_reset();
        test_directed();
        test_reset_mid_wait();
        test_misalign();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 clk  in  1  clock; all state updates on its rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 MemReadM  in  1  load in MEM stage.
REQ-004 MemWriteM  in  1  store in MEM stage.
REQ-005 Funct3M  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-006 ALUResultM  in  32  effective byte address.
REQ-007 WriteDataM  in  32  store data, right-aligned.
REQ-008 ReadDataM  out  32  formatted load result, consumed by the MEM/WB register.
REQ-009 StallM  out  1  freeze IF..MEM while an access is outstanding.
REQ-010 MisalignM  out  1  misaligned-access flag.
REQ-011 dmem_req  out  1  bus request.
REQ-012 dmem_we  out  1  bus write enable.
REQ-013 dmem_addr  out  32  word address: ALUResultM with [1:0] forced to 00.
REQ-014 dmem_wdata  out  32  lane-replicated store data.
REQ-015 dmem_be  out  4  byte enables.
REQ-016 dmem_ready  in  1  bus completes the request this cycle.
REQ-017 dmem_rdata  in  32  bus read word, valid when dmem_ready=1.

Function
REQ-018 The FSM SHALL have states IDLE, WAIT and DONE.
REQ-019 An access is pending when (MemReadM|MemWriteM)=1 and the access is not suppressed by REQ-033.
REQ-020 IDLE with access pending: dmem_req=1 and StallM=1 combinationally; dmem_ready=1 -> capture and go DONE; else -> WAIT.
REQ-021 WAIT: dmem_req=1, StallM=1; upstream inputs are held stable by the stall; dmem_ready=1 -> capture and go DONE.
REQ-022 DONE: dmem_req=0, StallM=0 for exactly one cycle; ReadDataM=captured value; unconditional -> IDLE.
REQ-023 Minimum access latency SHALL be 2 cycles (1 stall cycle); each wait cycle adds one.
REQ-024 ReadDataM SHALL be 0 outside DONE.
REQ-025 Load formatting: byte lane = addr[1:0], half lane = addr[1]; B/H sign-extend, BU/HU zero-extend, W passes through.
REQ-026 Store: SB be=0001<<addr[1:0], data byte replicated x4; SH be=0011<<(2*addr[1]), half replicated x2; SW be=1111.
REQ-027 dmem_be SHALL be 1111 for loads.
REQ-028 Funct3 011/110/111 SHALL be treated as word access.
REQ-029 MemReadM and MemWriteM both set -> store takes priority, dmem_we=1.
REQ-030 dmem_ready SHALL be ignored while dmem_req=0.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE and clear the captured data, regardless of state (including mid-WAIT).
REQ-032 While rst is asserted: ReadDataM=0, StallM=0, MisalignM=0, dmem_req=0, dmem_we=0.

Configuration
REQ-033 MISALIGN_TRAP_EN defined -> H/HU/SH with addr[0]=1, or W/SW with addr[1:0]!=00, SHALL:
  - raise MisalignM combinationally in IDLE;
  - suppress dmem_req;
  - not assert StallM;
  - drive ReadDataM=0.
REQ-034 MISALIGN_TRAP_EN undefined -> MisalignM tied 0; the halfword offset uses addr[1] only and word accesses ignore addr[1:0].

Verification
REQ-035 LW addr 0x100, dmem_ready=1 first cycle, rdata 0xDEADBEEF -> StallM 1 cycle; ReadDataM=0xDEADBEEF in DONE.
REQ-036 LB addr 0x103, rdata 0x80xxxxxx, 3 wait cycles -> StallM 4 cycles; ReadDataM=0xFFFFFF80; LBU gives 0x00000080.
REQ-037 SH addr 0x202, WriteDataM 0x1234ABCD -> dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_we=1, dmem_addr=0x200.
REQ-038 rst asserted while in WAIT -> next cycle dmem_req=0, StallM=0, state IDLE.
REQ-039 MISALIGN_TRAP_EN defined, LW addr 0x101 -> MisalignM=1, dmem_req=0, StallM=0; undefined -> word read at 0x100.
